mips_cpu_mem_arbiter: RTL and testbench

Single-master Avalon arbiter between the CPU's memory clients and the external bus. It multiplexes instruction-cache read misses, data-cache read misses and write-buffer drain writes onto one Avalon master port. It drives the write buffer's `active` input so that reads can take the bus between buffered writes. It sits directly downstream of the cache write buffer and the two caches.

---
 rtl/mips_cpu_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
// Single-master Avalon arbiter for the CPU memory clients: instruction-cache
// read misses, data-cache read misses and write-buffer drain writes share one
// Avalon master port. The state is registered; every bus output is decoded
// combinationally from the state and the current inputs.
//
// Optional feature macro: READ_PRIORITY_EN
//   undefined - reads wait for an empty write buffer (strict write-before-read)
//   defined   - a pending read takes the bus at the next write boundary
module mips_cpu_mem_arbiter #(
  parameter int IC_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction cache
  input  logic        ic_read,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_readdata,
  output logic        ic_waitrequest,
  // data cache
  input  logic        dc_read,
  input  logic [31:0] dc_addr,
  output logic [31:0] dc_readdata,
  output logic        dc_waitrequest,
  // write buffer
  input  logic        wb_write_en,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_writedata,
  input  logic [3:0]  wb_byteenable,
  input  logic        wb_empty,
  output logic        wb_active,
  output logic        wb_waitrequest,
  // Avalon master
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  // debug
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ_I = 2'd2,
    READ_D = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic read_pending;
  logic read_eligible;
  logic write_exit;
  logic write_done;

  assign read_pending = ic_read | dc_read;

`ifdef READ_PRIORITY_EN
  // A pending read may cut in at any write boundary.
  assign read_eligible = read_pending;
  assign write_exit    = wb_empty | read_pending;
`else
  // Reads only start once every buffered write has reached memory.
  assign read_eligible = read_pending & wb_empty;
  assign write_exit    = wb_empty;
`endif

  // A write word retires when the strobe is accepted by the slave.
  assign write_done = (state == WRITE) & wb_write_en & ~avm_waitrequest;

  // Next-state selection: arbitration in IDLE, write-run and read completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (read_eligible) begin
          if (IC_FIRST != 0) state_nxt = ic_read ? READ_I : READ_D;
          else               state_nxt = dc_read ? READ_D : READ_I;
        end else if (wb_write_en) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // A word in flight is never abandoned; the run ends only at a boundary.
        if (write_done) begin
          if (write_exit) state_nxt = IDLE;
        end else if (!wb_write_en && wb_empty) begin
          state_nxt = IDLE;
        end
      end
      READ_I, READ_D: begin
        if (!avm_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bus, cache and write-buffer outputs decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    avm_address    = 32'h0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = 32'h0;
    avm_byteenable = 4'h0;
    wb_active      = 1'b1;
    wb_waitrequest = 1'b1;
    ic_readdata    = 32'h0;
    ic_waitrequest = 1'b1;
    dc_readdata    = 32'h0;
    dc_waitrequest = 1'b1;
    case (state)
      WRITE: begin
        avm_write      = wb_write_en;
        avm_address    = wb_addr;
        avm_writedata  = wb_writedata;
        avm_byteenable = wb_byteenable;
        wb_waitrequest = avm_waitrequest;
      end
      READ_I: begin
        avm_read       = 1'b1;
        avm_address    = ic_addr;
        avm_byteenable = 4'hF;
        wb_active      = 1'b0;
        if (!avm_waitrequest) begin
          ic_readdata    = avm_readdata;
          ic_waitrequest = 1'b0;
        end
      end
      READ_D: begin
        avm_read       = 1'b1;
        avm_address    = dc_addr;
        avm_byteenable = 4'hF;
        wb_active      = 1'b0;
        if (!avm_waitrequest) begin
          dc_readdata    = avm_readdata;
          dc_waitrequest = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter
// Directed bench for mips_cpu_mem_arbiter. The environment (write buffer,
// Avalon slave with programmable wait states, cache requesters) lives here;
// a negedge process checks the per-state output rules every cycle and a
// transaction scoreboard checks the order and contents of bus completions.
module tb_mips_cpu_mem_arbiter;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_D = 2'd1;
  localparam logic [1:0] K_W = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  logic        clk;
  logic        rst;
  logic        ic_read, dc_read;
  logic [31:0] ic_addr, dc_addr;
  logic [31:0] ic_readdata, dc_readdata;
  logic        ic_waitrequest, dc_waitrequest;
  logic        wb_write_en, wb_empty, wb_active, wb_waitrequest;
  logic [31:0] wb_addr, wb_writedata;
  logic [3:0]  wb_byteenable;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [1:0]  state_out;

  // second instance, IC_FIRST=0, private requests and a zero-wait slave
  logic        ic_read0, dc_read0;
  logic [31:0] ic_readdata0, dc_readdata0;
  logic        ic_waitrequest0, dc_waitrequest0;
  logic        wb_active0, wb_waitrequest0;
  logic [31:0] avm_address0, avm_writedata0;
  logic        avm_read0, avm_write0;
  logic [3:0]  avm_byteenable0;
  logic [1:0]  state_out0;
  logic [31:0] rd0;
  logic        zero_wait0, wb_write_en0, wb_empty0;

  // write buffer model
  logic [31:0] wq_addr [8];
  logic [31:0] wq_data [8];
  logic [3:0]  wq_be   [8];
  logic [2:0]  wq_head;
  logic [3:0]  wq_cnt;

  // Avalon slave model
  logic [7:0]  slv_cnt, slv_wait;
  logic [31:0] slv_rdata;

  // negedge samples consumed at the next posedge
  logic        s_pop, s_strobe, s_wait, s_ic_done, s_dc_done;

  int          checks, failures;
  int          ic_done_n, dc_done_n;
  logic        mon_en;
  tr_t         sb_q[$];
  int          seq [16];
  int          wrv [16];
  int          done_at, exp_done_at;

  assign wb_write_en     = (wq_cnt != 4'd0);
  assign wb_empty        = (wq_cnt == 4'd0);
  assign wb_addr         = wq_addr[wq_head];
  assign wb_writedata    = wq_data[wq_head];
  assign wb_byteenable   = wq_be[wq_head];
  assign avm_readdata    = slv_rdata;
  assign avm_waitrequest = (avm_read | avm_write) ? (slv_cnt < slv_wait) : 1'b1;

  mips_cpu_mem_arbiter #(.IC_FIRST(1)) u_dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_readdata(ic_readdata),
    .ic_waitrequest(ic_waitrequest),
    .dc_read(dc_read), .dc_addr(dc_addr), .dc_readdata(dc_readdata),
    .dc_waitrequest(dc_waitrequest),
    .wb_write_en(wb_write_en), .wb_addr(wb_addr), .wb_writedata(wb_writedata),
    .wb_byteenable(wb_byteenable), .wb_empty(wb_empty), .wb_active(wb_active),
    .wb_waitrequest(wb_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .state_out(state_out)
  );

  mips_cpu_mem_arbiter #(.IC_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ic_read(ic_read0), .ic_addr(ic_addr), .ic_readdata(ic_readdata0),
    .ic_waitrequest(ic_waitrequest0),
    .dc_read(dc_read0), .dc_addr(dc_addr), .dc_readdata(dc_readdata0),
    .dc_waitrequest(dc_waitrequest0),
    .wb_write_en(wb_write_en0), .wb_addr(wb_addr), .wb_writedata(wb_writedata),
    .wb_byteenable(wb_byteenable), .wb_empty(wb_empty0), .wb_active(wb_active0),
    .wb_waitrequest(wb_waitrequest0),
    .avm_address(avm_address0), .avm_read(avm_read0), .avm_write(avm_write0),
    .avm_writedata(avm_writedata0), .avm_byteenable(avm_byteenable0),
    .avm_readdata(rd0), .avm_waitrequest(zero_wait0),
    .state_out(state_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {31'd0, got}, {31'd0, exp});
  endtask

  // Per-cycle output rules for the state reported on state_out, plus the
  // completion scoreboard.
  always @(negedge clk) begin
    logic [5:0]  ctl_exp;
    logic [31:0] ic_exp, dc_exp;
    tr_t         got, exp;
    if (mon_en) begin
      ic_exp = 32'h0;
      dc_exp = 32'h0;
      case (state_out)
        2'd0: ctl_exp = 6'b001111;
        2'd1: ctl_exp = {1'b0, wb_write_en, 1'b1, avm_waitrequest, 2'b11};
        2'd2: begin
          ctl_exp = {2'b10, 1'b0, 1'b1, avm_waitrequest, 1'b1};
          ic_exp  = avm_waitrequest ? 32'h0 : avm_readdata;
        end
        2'd3: begin
          ctl_exp = {2'b10, 1'b0, 1'b1, 1'b1, avm_waitrequest};
          dc_exp  = avm_waitrequest ? 32'h0 : avm_readdata;
        end
        default: ctl_exp = 6'b000000;
      endcase
      check1("state_known", $isunknown(state_out), 1'b0);
      check("ctl_rule", {26'd0, avm_read, avm_write, wb_active, wb_waitrequest,
                         ic_waitrequest, dc_waitrequest}, {26'd0, ctl_exp});
      check("ic_readdata_rule", ic_readdata, ic_exp);
      check("dc_readdata_rule", dc_readdata, dc_exp);
      if (state_out == 2'd1 && wb_write_en) begin
        check("wr_addr_rule", avm_address, wb_addr);
        check("wr_data_rule", avm_writedata, wb_writedata);
        check("wr_be_rule", {28'd0, avm_byteenable}, {28'd0, wb_byteenable});
      end
      if (state_out == 2'd2) check("ird_addr_rule", avm_address, ic_addr);
      if (state_out == 2'd3) check("drd_addr_rule", avm_address, dc_addr);
      if (state_out[1]) check("rd_be_rule", {28'd0, avm_byteenable}, 32'hF);

      if ((avm_read || avm_write) && avm_waitrequest === 1'b0) begin
        got.kind = avm_write ? K_W : ((ic_waitrequest === 1'b0) ? K_I : K_D);
        got.addr = avm_address;
        got.data = (got.kind == K_W) ? avm_writedata :
                   (got.kind == K_I) ? ic_readdata : dc_readdata;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_txn", {30'd0, got.kind}, 32'hFFFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          check("sb_kind", {30'd0, got.kind}, {30'd0, exp.kind});
          check("sb_addr", got.addr, exp.addr);
          check("sb_data", got.data, exp.data);
        end
      end
    end
    s_pop     = (wb_write_en && wb_waitrequest === 1'b0);
    s_strobe  = (avm_read === 1'b1) || (avm_write === 1'b1);
    s_wait    = (avm_waitrequest === 1'b1);
    s_ic_done = (ic_waitrequest === 1'b0);
    s_dc_done = (dc_waitrequest === 1'b0);
  end

  // Environment reaction to what was seen at the last negedge.
  task automatic update_env();
    if (s_pop) begin
      wq_head = wq_head + 3'd1;
      wq_cnt  = wq_cnt - 4'd1;
    end
    if (s_strobe && s_wait) slv_cnt = slv_cnt + 8'd1;
    else                    slv_cnt = 8'd0;
    if (s_ic_done) begin ic_read = 1'b0; ic_done_n++; end
    if (s_dc_done) begin dc_read = 1'b0; dc_done_n++; end
  endtask

  // One clock: react just after the edge, return 4 time units in (before negedge).
  task automatic cyc();
    @(posedge clk);
    #1;
    update_env();
    #3;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input bit expect_txn);
    logic [2:0] idx;
    idx = wq_head + wq_cnt[2:0];
    wq_addr[idx] = a;
    wq_data[idx] = d;
    wq_be[idx]   = be;
    wq_cnt       = wq_cnt + 4'd1;
    if (expect_txn) sb_q.push_back('{K_W, a, d});
  endtask

  // Record state_out and avm_write now and after each of n clocks.
  task automatic trace(input int n);
    seq[0] = int'(state_out);
    wrv[0] = int'(avm_write);
    for (int i = 1; i <= n; i++) begin
      cyc();
      seq[i] = int'(state_out);
      wrv[i] = int'(avm_write);
    end
  endtask

  // ev holds entry i in nibble i (entry 0 is the rightmost hex digit).
  task automatic check_seq(input string tag, input int n, input logic [63:0] ev,
                           input bit use_wr);
    for (int i = 0; i <= n; i++)
      check($sformatf("%s[%0d]", tag, i), use_wr ? wrv[i] : seq[i],
            {28'd0, ev[4*i +: 4]});
  endtask

  initial begin
    int ic0, dc0;
    checks = 0; failures = 0; ic_done_n = 0; dc_done_n = 0; mon_en = 1'b0;
    rst = 1'b0; ic_read = 1'b0; dc_read = 1'b0; ic_addr = 32'h0; dc_addr = 32'h0;
    wq_head = 3'd0; wq_cnt = 4'd0; slv_cnt = 8'd0; slv_wait = 8'd0;
    slv_rdata = 32'h0; s_pop = 1'b0; s_strobe = 1'b0; s_wait = 1'b0;
    s_ic_done = 1'b0; s_dc_done = 1'b0;
    ic_read0 = 1'b0; dc_read0 = 1'b0; rd0 = 32'hA5A5_0000; zero_wait0 = 1'b0;
    wb_write_en0 = 1'b0; wb_empty0 = 1'b1;
    for (int i = 0; i < 8; i++) begin wq_addr[i] = 32'h0; wq_data[i] = 32'h0; wq_be[i] = 4'h0; end

    // ---- reset held two cycles with every requester active ----
    cyc();
    mon_en = 1'b1;
    ic_read = 1'b1; dc_read = 1'b1; ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0200;
    push_word(32'h0000_0300, 32'h5555_AAAA, 4'hF, 1'b0);
    cyc(); cyc();
    check1("rst_avm_read", avm_read, 1'b0);
    check1("rst_avm_write", avm_write, 1'b0);
    check("rst_state_out", {30'd0, state_out}, 32'd0);
    check1("rst_wb_active", wb_active, 1'b1);
    check("rst_waitrequests", {29'd0, ic_waitrequest, dc_waitrequest, wb_waitrequest}, 32'd7);
    check("rst_ic_readdata", ic_readdata, 32'h0);
    check("rst_dc_readdata", dc_readdata, 32'h0);
    ic_read = 1'b0; dc_read = 1'b0; wq_cnt = 4'd0; wq_head = 3'd0;
    rst = 1'b1;
    cyc();

    // ---- instruction read, two wait states ----
    slv_wait = 8'd2; slv_rdata = 32'h1234_5678; ic_addr = 32'hBFC0_0000;
    sb_q.push_back('{K_I, 32'hBFC0_0000, 32'h1234_5678});
    ic0 = ic_done_n;
    ic_read = 1'b1;
    trace(4);
    check_seq("iread_state", 4, 64'h02220, 1'b0);
    cyc();
    check("iread_completions", ic_done_n - ic0, 32'd1);
    check1("iread_req_dropped", ic_read, 1'b0);

    // ---- simultaneous reads, instruction cache first ----
    slv_wait = 8'd0; slv_rdata = 32'hCAFE_0001;
    ic_addr = 32'h0040_0000; dc_addr = 32'h1001_0000;
    sb_q.push_back('{K_I, 32'h0040_0000, 32'hCAFE_0001});
    sb_q.push_back('{K_D, 32'h1001_0000, 32'hCAFE_0001});
    ic_read = 1'b1; dc_read = 1'b1;
    trace(4);
    check_seq("both_icfirst_state", 4, 64'h03020, 1'b0);
    cyc();

    // ---- simultaneous reads on the IC_FIRST=0 instance ----
    ic_read0 = 1'b1; dc_read0 = 1'b1;
    check("icf0_start", {30'd0, state_out0}, 32'd0);
    cyc();
    check("icf0_first_state", {30'd0, state_out0}, 32'd3);
    check1("icf0_dc_wait", dc_waitrequest0, 1'b0);
    check1("icf0_ic_wait_hold", ic_waitrequest0, 1'b1);
    check("icf0_dc_data", dc_readdata0, 32'hA5A5_0000);
    check("icf0_dc_addr", avm_address0, 32'h1001_0000);
    dc_read0 = 1'b0;
    cyc();
    check("icf0_gap", {30'd0, state_out0}, 32'd0);
    cyc();
    check("icf0_second_state", {30'd0, state_out0}, 32'd2);
    check1("icf0_ic_wait", ic_waitrequest0, 1'b0);
    check("icf0_ic_data", ic_readdata0, 32'hA5A5_0000);
    check1("icf0_avm_read", avm_read0, 1'b1);
    ic_read0 = 1'b0;
    cyc();
    check("icf0_end", {30'd0, state_out0}, 32'd0);

    // ---- write drain, three words, zero wait states ----
    push_word(32'h1000_0000, 32'h1111_1111, 4'b1111, 1'b1);
    push_word(32'h1000_0004, 32'h2222_2222, 4'b0011, 1'b1);
    push_word(32'h1000_0008, 32'h3333_3333, 4'b1000, 1'b1);
    trace(5);
    check_seq("drain_state", 5, 64'h011110, 1'b0);
    check_seq("drain_write", 5, 64'h001110, 1'b1);
    check("drain_buffer_empty", {28'd0, wq_cnt}, 32'd0);

    // ---- write run with one wait state per word ----
    slv_wait = 8'd1;
    push_word(32'h2000_0010, 32'h4444_4444, 4'b0110, 1'b1);
    push_word(32'h2000_0014, 32'h5555_5555, 4'b1100, 1'b1);
    trace(6);
    check_seq("wait_wr_state", 6, 64'h0111110, 1'b0);
    slv_wait = 8'd0;
    cyc();

    // ---- data read raised while three writes are buffered ----
    push_word(32'h3000_0000, 32'h6666_6666, 4'hF, 1'b1);
`ifdef READ_PRIORITY_EN
    sb_q.push_back('{K_D, 32'h1001_0040, 32'hDEAD_BEEF});
    exp_done_at = 3;
`else
    exp_done_at = 6;
`endif
    push_word(32'h3000_0004, 32'h7777_7777, 4'hF, 1'b1);
    push_word(32'h3000_0008, 32'h8888_8888, 4'hF, 1'b1);
`ifndef READ_PRIORITY_EN
    sb_q.push_back('{K_D, 32'h1001_0040, 32'hDEAD_BEEF});
`endif
    cyc();
    check("rdw_in_write", {30'd0, state_out}, 32'd1);
    dc_addr = 32'h1001_0040; slv_rdata = 32'hDEAD_BEEF; dc_read = 1'b1;
    done_at = -1;
    for (int j = 2; j <= 20; j++) begin
      cyc();
      if (dc_waitrequest === 1'b0) begin
        done_at = j;
        check1("rdw_wb_active_in_read", wb_active, 1'b0);
        break;
      end
    end
    check("rdw_read_done_cycle", done_at, exp_done_at);
    for (int j = 0; j < 8; j++) cyc();
    check("rdw_buffer_empty", {28'd0, wq_cnt}, 32'd0);
    check("rdw_state_idle", {30'd0, state_out}, 32'd0);

    // ---- reset while a data read waits on the slave ----
    slv_wait = 8'd100; dc_addr = 32'h1001_0080;
    dc0 = dc_done_n;
    dc_read = 1'b1;
    cyc();
    check("mrst_in_read", {30'd0, state_out}, 32'd3);
    cyc();
    rst = 1'b0;
    cyc();
    check1("mrst_avm_read", avm_read, 1'b0);
    check("mrst_state", {30'd0, state_out}, 32'd0);
    check1("mrst_dc_wait", dc_waitrequest, 1'b1);
    dc_read = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check("mrst_no_completion", dc_done_n - dc0, 32'd0);
    check1("mrst_after_release_read", avm_read, 1'b0);
    slv_wait = 8'd0;
    cyc();

    check("sb_all_consumed", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
